// File: rtl/octo_irq_encoder_pkg.sv
// rtl/octo_irq_encoder_pkg.sv - shared constants and FSM state type for octo_irq_encoder
package octo_enc_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/octo_irq_encoder_if.sv
// rtl/octo_irq_encoder_if.sv - request/handshake bundle for octo_irq_encoder (ovf present under OCTO_IRQ_ENC_OVF_EN)
interface octo_irq_encoder_if;
    import octo_enc_pkg::*;

    logic [N_REQ-1:0] req_in;
    logic [N_REQ-1:0] mask;
    logic             ack;
    logic [IDX_W-1:0] code_out;
    logic             valid;
    logic [N_REQ-1:0] pending;
`ifdef OCTO_IRQ_ENC_OVF_EN
    logic [N_REQ-1:0] ovf;

    modport master (output req_in, mask, ack, input code_out, valid, pending, ovf);
    modport slave  (input req_in, mask, ack, output code_out, valid, pending, ovf);
`else
    modport master (output req_in, mask, ack, input code_out, valid, pending);
    modport slave  (input req_in, mask, ack, output code_out, valid, pending);
`endif

endinterface

// File: rtl/octo_irq_encoder_prio_enc8.sv
// rtl/octo_irq_encoder_prio_enc8.sv - combinational 8-to-3 highest-set-index encoder with any-set flag
module prio_enc8
    import octo_enc_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/octo_irq_encoder.sv
// rtl/octo_irq_encoder.sv - registered 8-to-3 priority interrupt encoder with edge capture and valid/ack (OCTO_IRQ_ENC_OVF_EN adds ovf)
module octo_irq_encoder
    import octo_enc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    octo_irq_encoder_if.slave   bus
);

    state_t           state, state_nxt;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending_q, pending_nxt;
    logic [IDX_W-1:0] code_q, code_nxt;
    logic             valid_q, valid_nxt;

    logic [N_REQ-1:0] req_edge;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] cand_idx;
    logic             cand_any;

    assign req_edge = bus.req_in & ~req_q;
    assign cand     = pending_q & bus.mask;

    // Only the presented line can be cleared, and only by an ack in PRESENT.
    always_comb begin
        clr = '0;
        if (state == PRESENT && bus.ack) begin
            clr[code_q] = 1'b1;
        end
    end

    // A fresh edge in the ack cycle wins over the clear.
    assign pending_nxt = (pending_q & ~clr) | req_edge;

    prio_enc8 u_prio (
        .vec (cand),
        .idx (cand_idx),
        .any (cand_any)
    );

    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        valid_nxt = valid_q;
        unique case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (cand_any) begin
                    code_nxt  = cand_idx;
                    valid_nxt = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                valid_nxt = 1'b1;
                if (bus.ack) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_q     <= '0;
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            req_q     <= bus.req_in;
            pending_q <= pending_nxt;
            code_q    <= code_nxt;
            valid_q   <= valid_nxt;
        end
    end

    assign bus.code_out = code_q;
    assign bus.valid    = valid_q;
    assign bus.pending  = pending_q;

`ifdef OCTO_IRQ_ENC_OVF_EN
    logic [N_REQ-1:0] ovf_q;

    // Lost event: edge on a line still pending that is not being acked this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= (ovf_q & ~clr) | (req_edge & pending_q & ~clr);
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: doc/octo_irq_encoder.md
Name: octo_irq_encoder

Overview:
- Registered 8-to-3 priority encoder with request capture and a valid/ack handshake. It is the encode-side counterpart of the one-hot 3-to-8 octal decoder.
- Collects rising edges on 8 request lines into a pending register and presents the highest-priority unmasked pending index as a 3-bit code.
- Holds the presented code stable until the consumer (CPU control/interrupt logic) acknowledges it.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8, and the RTL is not required to support other values.
- IDX_W, 3, code width; equals log2(N_REQ).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low; one clock, reset sampled on the clk rising edge.
- req_in  input  8  level request lines; a 0->1 transition between consecutive samples is an event.
- mask  input  8  1 = line enabled for presentation; 0 = line keeps pending but is not presented.
- ack  input  1  consumer accepts the presented code; meaningful only while valid=1.
- code_out  output  3  index of the presented line.
- valid  output  1  code_out is valid and stable.
- pending  output  8  current pending register, unmasked view.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears req_q, pending, code_out, valid and state. After reset: code_out=3'd0, valid=0, pending=8'h00, state=IDLE.
  - Reset overrides everything, including an in-progress presentation.
  - A line already high when reset is released counts as an edge (req_q resets to 0).
- Edge capture, each cycle: req_q <= req_in; edge[i] = req_in[i] & ~req_q[i]; pending[i] set on edge[i].
- Clear: pending[i] cleared when state=PRESENT, ack=1, and code_out=i. If edge[i] occurs in the same cycle, set wins and the bit stays 1.
- Candidate selection: cand = pending & mask. Priority: the highest set index wins, so bit 7 has top priority.
- FSM:
  - IDLE: if cand != 0, load code_out with the highest index of cand, set valid=1, go to PRESENT. Otherwise stay, valid=0.
  - PRESENT: valid=1 and code_out frozen. Changes to mask or to pending on other lines, including higher priority, do not alter code_out. On ack=1: valid<=0, clear the presented bit, go to IDLE.
- Latency: req_in first sampled high at edge E0 -> pending set after E0 -> valid=1 after E1, i.e. 2 cycles.
- After ack, valid is low for at least 1 cycle before the next presentation. Back-to-back throughput is 1 code per 2 cycles.
- ack while valid=0 is ignored.
- A repeated edge on an already-pending line merges into it; there is no count.
- A masked line whose pending bit becomes unmasked is eligible at the next IDLE evaluation.

Optional Feature:
- Macro: OCTO_IRQ_ENC_OVF_EN.
- With the macro defined:
  - Adds output port ovf, 8 bits.
  - ovf[i] is set when edge[i] occurs while pending[i]=1 (lost event), except in the cycle pending[i] is being cleared by ack.
  - ovf[i] is cleared when line i is acked.
  - ovf resets to 8'h00.
- Without the macro: the ovf port and its logic are absent, and repeated edges merge silently.

Decomposition:
- Package octo_enc_pkg: N_REQ=8, IDX_W=3, state enum {IDLE, PRESENT}.
- Sub-module prio_enc8: combinational 8-bit input -> 3-bit highest-set index plus any-set flag. It is the inverse of the octal decoder, and the top instantiates it on cand.

Test Plan:
- Reset with req_in=8'h00, then hold 5 cycles -> valid=0, code_out=0, pending=8'h00 every cycle.
- mask=8'hFF, pulse req_in[5] 0->1 at E0 -> pending=8'h20 after E0; valid=1, code_out=5 after E1; ack at E2 -> valid=0, pending=8'h00.
- req_in=8'h12 in one cycle (lines 1 and 4) -> code_out=4 first; after ack, 1 idle cycle, then code_out=1. Raising line 7 during the line-4 presentation does not change code_out=4 until ack.
- mask=8'hF7, edge on line 3 -> pending=8'h08, valid stays 0 for 10 cycles; set mask=8'hFF -> valid=1, code_out=3 two cycles later.
- Presenting code 2, drive ack=1 with a new edge on line 2 the same cycle -> pending[2] remains 1, code 2 re-presented after 1 idle cycle. With OCTO_IRQ_ENC_OVF_EN defined, ovf[2] stays 0.
- rst_n=0 for one cycle while valid=1 and req_in=8'h01 held high -> all outputs cleared. After release: pending=8'h01 after next edge, then valid=1, code_out=0.
